// File: rtl/byte_inv_fifo_pkg.sv
// Shared byte types and the inversion transform used by every stage on the y side.
typedef logic [7:0] x_t;

package byte_inv_fifo_pkg;
  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] y_t;

  function automatic y_t inv_byte(input x_t x);
    return y_t'(~x);
  endfunction
endpackage

// File: rtl/byte_inv_fifo_if.sv
// Source-side and consumer-side handshakes of the inverting byte FIFO.
interface byte_inv_fifo_if
  import byte_inv_fifo_pkg::*;
#(
  parameter int DEPTH = 4
);
  logic                         flush;
  logic                         in_valid;
  logic                         in_ready;
  x_t                           in_data;
  logic                         out_valid;
  logic                         out_ready;
  y_t                           out_data;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/byte_fifo_mem.sv
// DEPTH x byte register array: one synchronous write port, one asynchronous read port.
module byte_fifo_mem
  import byte_inv_fifo_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  x_t            wdata_i,
  input  logic [AW-1:0] raddr_i,
  output x_t            rdata_o
);

  logic [BYTE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/byte_inv_fifo.sv
// Circular byte FIFO between a byte source and the y-side consumer; the inverse is
// applied on the read side so storage always holds the raw source bytes.
module byte_inv_fifo
  import byte_inv_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  byte_inv_fifo_if.slave        bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          in_ready_w, out_valid_w;
  logic          push, pop;
  x_t            rd_byte;

  // Handshake flags come from the count register alone, so ready never waits on the consumer.
  assign in_ready_w  = (count_q != CW'(DEPTH));
  assign out_valid_w = (count_q != '0);
  assign push        = bus.in_valid  && in_ready_w;
  assign pop         = out_valid_w   && bus.out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A push racing a flush is dropped so no stale write lands after the clear.
  byte_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (push && !bus.flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_byte)
  );

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = inv_byte(rd_byte);
  assign bus.count     = count_q;

endmodule
